// File: rtl/alu_pipe_if.sv
// alu_pipe_if -- request/result bus for alu_pipe.
//   in_valid/in_ready : request handshake carrying operands a, b and opcode sel
//   out_valid/out_ready : result handshake carrying out and flags {err, ovf, neg, zero}
//   master : requester/consumer side, slave : ALU side
interface alu_pipe_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [3:0]       flags;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, out, flags
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, out, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe -- signed ALU with a single output register and an iterative divider.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : alu_pipe_if slave port (request in, result out, flags {err, ovf, neg, zero})
// Opcodes 1..9 and illegal opcodes complete at the acceptance edge; opcodes 10/11
// run a WIDTH-step restoring divider on operand magnitudes and load the result
// from HOLD one edge after the last iteration.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic [3:0]       r_flags;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
   logic             r_ovf;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_div_op;
   logic               w_load;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_dif;
   logic [2*WIDTH-1:0] w_prod;
   logic [SHW-1:0]     w_sh;
   logic signed [WIDTH-1:0] w_a_s;
   logic [WIDTH-1:0]   w_res;
   logic               w_err;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_q_fin;
   logic [WIDTH-1:0]   w_r_fin;
   logic [WIDTH-1:0]   w_ld_res;
   logic               w_ld_err;
   logic               w_ld_ovf;

   assign w_in_ready  = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_is_div_op = (bus.sel == 4'd10) || (bus.sel == 4'd11);

   assign w_sum  = bus.a + bus.b;
   assign w_dif  = bus.a - bus.b;
   // Sign-extended operands make the unsigned 2W-bit product equal the signed one.
   assign w_prod = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
   assign w_sh   = bus.b[SHW-1:0];
   assign w_a_s  = bus.a;

   always_comb begin
      w_res = '0;
      w_err = 1'b0;
      w_ovf = 1'b0;
      case (bus.sel)
         4'd1: begin
            w_res = w_sum;
            w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'd2: begin
            w_res = w_dif;
            w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'd3: begin
            w_res = w_prod[WIDTH-1:0];
            w_ovf = w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}};
         end
         4'd4:  w_res = bus.a & bus.b;
         4'd5:  w_res = bus.a | bus.b;
         4'd6:  w_res = bus.a ^ bus.b;
         4'd7:  w_res = bus.a << w_sh;
         4'd8:  w_res = w_a_s >>> w_sh;
         4'd9:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         4'd10, 4'd11: w_res = '0;
         default: w_err = 1'b1;
      endcase
   end

   // Divider works on magnitudes; -MIN wraps to 2^(WIDTH-1), which is still correct unsigned.
   assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};

   // Divide by zero leaves |a| in the remainder naturally; only the quotient needs forcing.
   assign w_q_fin = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
   assign w_r_fin = r_neg_r ? -r_rem : r_rem;

   assign w_load   = (r_state == S_HOLD) ? (!r_out_valid || bus.out_ready)
                                         : (w_accept && !w_is_div_op);
   assign w_ld_res = (r_state == S_HOLD) ? (r_is_rem ? w_r_fin : w_q_fin) : w_res;
   assign w_ld_err = (r_state == S_HOLD) ? r_dz  : w_err;
   assign w_ld_ovf = (r_state == S_HOLD) ? r_ovf : w_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_flags     <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
         r_is_rem    <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dz        <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_load) begin
            r_out       <= w_ld_res;
            r_flags     <= {w_ld_err, w_ld_ovf, w_ld_res[WIDTH-1], (w_ld_res == '0)};
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_div_op) begin
                  r_state  <= S_DIV;
                  r_quo    <= w_abs_a;
                  r_rem    <= '0;
                  r_dvs    <= w_abs_b;
                  r_cnt    <= CW'(WIDTH);
                  r_is_rem <= (bus.sel == 4'd11);
                  r_neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  r_neg_r  <= bus.a[WIDTH-1];
                  r_dz     <= (bus.b == '0);
                  r_ovf    <= (bus.a == MINV) && (bus.b == '1);
               end
            end
            S_DIV: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= S_HOLD;
            end
            S_HOLD: begin
               if (w_load) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.flags     = r_flags;
endmodule
